// File: rtl/core_result_arbiter_if.sv
// Result-collection bus between the core array, the arbiter and the host/UART consumer.
// master: arbiter side (reads core buffers, drives the result port).
// slave : environment side (drives core buffers and out_ready, observes results).
interface core_result_arbiter_if #(
  parameter int NUM_CORES = 61,
  parameter int DATA_W    = 32
);
  localparam int CORE_W = $clog2(NUM_CORES);

  logic [NUM_CORES*DATA_W-1:0] buf_val_1_s;
  logic [NUM_CORES*DATA_W-1:0] buf_val_2_s;
  logic [NUM_CORES-1:0]        buf_flag_s;
  logic                        out_ready;
  logic                        out_valid;
  logic [CORE_W-1:0]           out_core;
  logic [DATA_W-1:0]           out_val_1;
  logic [DATA_W-1:0]           out_val_2;
  logic [CORE_W:0]             served_count;
  logic                        all_done;
  logic [DATA_W-1:0]           best_val;
  logic [CORE_W-1:0]           best_core;

  modport master (
    input  buf_val_1_s, buf_val_2_s, buf_flag_s, out_ready,
    output out_valid, out_core, out_val_1, out_val_2,
           served_count, all_done, best_val, best_core
  );

  modport slave (
    output buf_val_1_s, buf_val_2_s, buf_flag_s, out_ready,
    input  out_valid, out_core, out_val_1, out_val_2,
           served_count, all_done, best_val, best_core
  );
endinterface

// File: rtl/core_result_arbiter.sv
// Round-robin collector for per-core result buffers. Each raised buf_flag is served once
// (until the flag drops and re-arms it); the core's value pair is latched and presented on
// a valid/ready port. All outputs are registered.
// Optional feature macro: RESULT_BEST_EN (tracks max accepted out_val_1 and its core).
module core_result_arbiter #(
  parameter int NUM_CORES = 61,
  parameter int DATA_W    = 32
) (
  input  logic                         Clk,
  input  logic                         Reset,
  core_result_arbiter_if.master        bus
);
  localparam int CORE_W = $clog2(NUM_CORES);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t                             state;
  logic [NUM_CORES-1:0]               served, served_nx, eligible, hold_mask;
  logic [CORE_W-1:0]                  ptr, sel, pick, pick_hi, pick_lo;
  logic                               hi_found;
  logic [CORE_W:0]                    cnt;
  logic [NUM_CORES-1:0][DATA_W-1:0]   v1_arr, v2_arr;

  // Flattened buses have the same layout as a packed per-core array.
  assign v1_arr   = bus.buf_val_1_s;
  assign v2_arr   = bus.buf_val_2_s;
  assign eligible = bus.buf_flag_s & ~served;

  // Round-robin pick: lowest eligible index >= ptr, else lowest eligible overall (wrap).
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    hi_found = 1'b0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (eligible[i]) begin
        pick_lo = CORE_W'(i);
        if (i >= int'(ptr)) begin
          pick_hi  = CORE_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    pick = hi_found ? pick_hi : pick_lo;
  end

  // Served mask: re-arm on a low flag unless that core is being held; mark the granted core.
  always_comb begin
    hold_mask = (state == HOLD) ? (NUM_CORES'(1) << sel) : '0;
    served_nx = served & (bus.buf_flag_s | hold_mask);
    if (state == GRANT) served_nx[sel] = 1'b1;
  end

  // Popcount of the served mask.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) cnt = cnt + {{CORE_W{1'b0}}, served[i]};
  end

  // Arbiter FSM with registered result port and status.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state            <= IDLE;
      served           <= '0;
      ptr              <= '0;
      sel              <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_core     <= '0;
      bus.out_val_1    <= '0;
      bus.out_val_2    <= '0;
      bus.served_count <= '0;
      bus.all_done     <= 1'b0;
    end else begin
      served           <= served_nx;
      bus.served_count <= cnt;
      bus.all_done     <= (cnt == (CORE_W+1)'(NUM_CORES));
      case (state)
        IDLE: if (|eligible) begin
          sel   <= pick;
          state <= GRANT;
        end
        GRANT: begin
          bus.out_val_1 <= v1_arr[sel];
          bus.out_val_2 <= v2_arr[sel];
          bus.out_core  <= sel;
          bus.out_valid <= 1'b1;
          ptr           <= (sel == CORE_W'(NUM_CORES-1)) ? '0 : sel + 1'b1;
          state         <= HOLD;
        end
        HOLD: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RESULT_BEST_EN
  logic best_seen;

  // Track the largest accepted value 1; strict compare keeps the earlier core on ties.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      best_seen     <= 1'b0;
      bus.best_val  <= '0;
      bus.best_core <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      best_seen <= 1'b1;
      if (!best_seen || bus.out_val_1 > bus.best_val) begin
        bus.best_val  <= bus.out_val_1;
        bus.best_core <= bus.out_core;
      end
    end
  end
`else
  assign bus.best_val  = '0;
  assign bus.best_core = '0;
`endif

endmodule

// File: tb/tb_core_result_arbiter.sv
// Directed bench for core_result_arbiter: reset, single grant, round-robin order and wrap,
// stall with changing inputs, full sweep plus reset mid-hold, best-value tracking.
module tb_core_result_arbiter;
  localparam int NC = 61;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   vec = 0;
  int   errs = 0;

  core_result_arbiter_if #(.NUM_CORES(NC), .DATA_W(DW)) bif ();

  core_result_arbiter #(.NUM_CORES(NC), .DATA_W(DW)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bif.master)
  );

  always #5 clk = ~clk;

  // Drive/sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vals(input int c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bif.buf_val_1_s[DW*c +: DW] = a;
    bif.buf_val_2_s[DW*c +: DW] = b;
  endtask

  task automatic default_vals();
    for (int i = 0; i < NC; i++) set_vals(i, 32'h1000 + i, 32'h2000 + i);
  endtask

  task automatic do_reset();
    bif.buf_flag_s = '0;
    bif.out_ready  = 1'b0;
    default_vals();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Poll out_valid for up to max cycles; ok=0 on timeout.
  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (bif.out_valid) begin ok = 1'b1; return; end
      tick();
    end
    ok = bif.out_valid;
  endtask

  task automatic test_reset();
    default_vals();
    bif.out_ready  = 1'b0;
    bif.buf_flag_s = '1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++;
      if (bif.out_valid !== 1'b0 || bif.served_count !== 7'd0) begin
        errs++;
        $display("FAIL reset_hold: valid=%b count=%0d want 0/0", bif.out_valid, bif.served_count);
      end
    end
    rst_n = 1'b1;
    tick();
    vec++;
    if (bif.out_valid !== 1'b0) begin
      errs++; $display("FAIL reset_c1_valid: got %b want 0", bif.out_valid);
    end
    tick();
    vec++;
    if (bif.out_valid !== 1'b1 || bif.out_core !== 6'd0) begin
      errs++;
      $display("FAIL reset_c2: valid=%b core=%0d want 1/0", bif.out_valid, bif.out_core);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_vals(5, 32'h0000_00AA, 32'h0000_0055);
    bif.out_ready  = 1'b1;
    bif.buf_flag_s[5] = 1'b1;
    tick();
    vec++;
    if (bif.out_valid !== 1'b0) begin
      errs++; $display("FAIL single_lat1: valid=%b want 0", bif.out_valid);
    end
    tick();
    vec++;
    if (bif.out_valid !== 1'b1 || bif.out_core !== 6'd5 ||
        bif.out_val_1 !== 32'hAA || bif.out_val_2 !== 32'h55) begin
      errs++;
      $display("FAIL single_data: valid=%b core=%0d v1=%h v2=%h want 1/5/aa/55",
               bif.out_valid, bif.out_core, bif.out_val_1, bif.out_val_2);
    end
    tick();
    vec++;
    if (bif.served_count !== 7'd1) begin
      errs++; $display("FAIL single_count: got %0d want 1", bif.served_count);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vec++;
      if (bif.out_valid !== 1'b0) begin
        errs++; $display("FAIL single_no_regrant: cycle %0d valid=%b want 0", i, bif.out_valid);
      end
    end
  endtask

  task automatic test_round_robin();
    int got[3];
    int n;
    bit ok;
    do_reset();
    bif.out_ready = 1'b1;
    bif.buf_flag_s[3]  = 1'b1;
    bif.buf_flag_s[7]  = 1'b1;
    bif.buf_flag_s[60] = 1'b1;
    n = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      tick();
      if (bif.out_valid) begin
        got[n] = int'(bif.out_core);
        vec++;
        if (bif.out_val_1 !== 32'h1000 + got[n]) begin
          errs++; $display("FAIL rr_val: core %0d v1=%h", got[n], bif.out_val_1);
        end
        n++;
      end
    end
    vec++;
    if (n != 3 || got[0] != 3 || got[1] != 7 || got[2] != 60) begin
      errs++;
      $display("FAIL rr_order: n=%0d got %0d,%0d,%0d want 3,7,60", n, got[0], got[1], got[2]);
    end
    // Re-arm core 3 and core 7 together; ptr has wrapped to 0 so 3 comes first.
    bif.buf_flag_s[3] = 1'b0;
    bif.buf_flag_s[7] = 1'b0;
    tick(); tick();
    bif.buf_flag_s[3] = 1'b1;
    bif.buf_flag_s[7] = 1'b1;
    wait_valid(10, ok);
    vec++;
    if (!ok || bif.out_core !== 6'd3) begin
      errs++; $display("FAIL rr_rearm: ok=%b core=%0d want 3", ok, bif.out_core);
    end
    tick();
    wait_valid(10, ok);
    vec++;
    if (!ok || bif.out_core !== 6'd7) begin
      errs++; $display("FAIL rr_wrap_next: ok=%b core=%0d want 7", ok, bif.out_core);
    end
  endtask

  task automatic test_hold();
    bit ok;
    do_reset();
    bif.buf_flag_s[7] = 1'b1;
    wait_valid(10, ok);
    vec++;
    if (!ok) begin
      errs++; $display("FAIL hold_grant: timeout waiting for valid");
    end
    bif.buf_flag_s[7] = 1'b0;
    set_vals(7, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    for (int i = 0; i < 10; i++) begin
      tick();
      vec++;
      if (bif.out_valid !== 1'b1 || bif.out_core !== 6'd7 ||
          bif.out_val_1 !== 32'h1007 || bif.out_val_2 !== 32'h2007) begin
        errs++;
        $display("FAIL hold_stable: cyc %0d valid=%b core=%0d v1=%h v2=%h want 1/7/1007/2007",
                 i, bif.out_valid, bif.out_core, bif.out_val_1, bif.out_val_2);
      end
    end
    bif.out_ready = 1'b1;
    tick();
    vec++;
    if (bif.out_valid !== 1'b0) begin
      errs++; $display("FAIL hold_accept: valid=%b want 0", bif.out_valid);
    end
  endtask

  task automatic test_all_cores();
    int n;
    bit ok;
    do_reset();
    bif.out_ready  = 1'b1;
    bif.buf_flag_s = '1;
    n = 0;
    for (int c = 0; c < NC*3 + 20 && n < NC; c++) begin
      tick();
      if (bif.out_valid) begin
        vec++;
        if (bif.out_core !== 6'(n)) begin
          errs++; $display("FAIL all_order: got %0d want %0d", bif.out_core, n);
        end
        n++;
      end
    end
    tick();
    vec++;
    if (n != NC || bif.all_done !== 1'b1 || bif.served_count !== 7'd61) begin
      errs++;
      $display("FAIL all_done: n=%0d done=%b count=%0d want 61/1/61", n, bif.all_done, bif.served_count);
    end
    // Park a result in HOLD, then reset on top of it.
    bif.out_ready = 1'b0;
    bif.buf_flag_s[0] = 1'b0;
    tick(); tick();
    bif.buf_flag_s[0] = 1'b1;
    wait_valid(10, ok);
    vec++;
    if (!ok || bif.out_core !== 6'd0) begin
      errs++; $display("FAIL all_rehold: ok=%b core=%0d want 0", ok, bif.out_core);
    end
    rst_n = 1'b0;
    tick();
    vec++;
    if (bif.out_valid !== 1'b0 || bif.served_count !== 7'd0) begin
      errs++;
      $display("FAIL reset_mid_hold: valid=%b count=%0d want 0/0", bif.out_valid, bif.served_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_best();
    logic [DW-1:0] exp_val;
    logic [5:0]    exp_core;
    do_reset();
    set_vals(1, 32'd10, 32'd0);
    set_vals(2, 32'd40, 32'd0);
    set_vals(3, 32'd40, 32'd0);
    bif.out_ready = 1'b1;
    bif.buf_flag_s[1] = 1'b1;
    bif.buf_flag_s[2] = 1'b1;
    bif.buf_flag_s[3] = 1'b1;
    for (int i = 0; i < 15; i++) tick();
`ifdef RESULT_BEST_EN
    exp_val  = 32'd40;
    exp_core = 6'd2;
`else
    exp_val  = 32'd0;
    exp_core = 6'd0;
`endif
    vec++;
    if (bif.best_val !== exp_val || bif.best_core !== exp_core) begin
      errs++;
      $display("FAIL best: val=%0d core=%0d want %0d/%0d", bif.best_val, bif.best_core, exp_val, exp_core);
    end
    vec++;
    if (bif.served_count !== 7'd3) begin
      errs++; $display("FAIL best_count: got %0d want 3", bif.served_count);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bif.buf_flag_s  = '0;
    bif.out_ready   = 1'b0;
    bif.buf_val_1_s = '0;
    bif.buf_val_2_s = '0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_all_cores();
    test_best();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
